// File: rtl/divisor_clk_multi_if.sv
// Purpose : control/status bundle for the multi-channel clock divider.
// Signals : i_en, i_mode, i_div, i_load, i_sync   -> divider inputs
//           o_divclk, o_tick, o_pending          <- divider outputs (registered)
// The slave modport is the divider, the master modport drives it.
interface divisor_clk_multi_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned DIV_W = 7
);
    logic [N_CH-1:0]       i_en;
    logic [N_CH-1:0]       i_mode;
    logic [N_CH*DIV_W-1:0] i_div;
    logic [N_CH-1:0]       i_load;
    logic                  i_sync;
    logic [N_CH-1:0]       o_divclk;
    logic [N_CH-1:0]       o_tick;
    logic [N_CH-1:0]       o_pending;

    modport master (
        output i_en, i_mode, i_div, i_load, i_sync,
        input  o_divclk, o_tick, o_pending
    );

    modport slave (
        input  i_en, i_mode, i_div, i_load, i_sync,
        output o_divclk, o_tick, o_pending
    );
endinterface

// File: rtl/divisor_clk_multi.sv
// Purpose : N_CH independent runtime-programmable clock dividers with toggle
//           (50% duty) or single-cycle pulse output, glitch-free divisor
//           reload at period boundaries and a global phase-align strobe.
// Ports   : i_clk    - system clock, rising edge
//           i_reset  - synchronous active-low reset
//           bus      - divisor_clk_multi_if.slave (enable, mode, divisor,
//                      load, sync in; divided clock, tick, pending out)
module divisor_clk_multi #(
    parameter int unsigned      N_CH    = 2,
    parameter int unsigned      DIV_W   = 7,
    parameter int unsigned      CNT_W   = 10,
    parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(9)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    divisor_clk_multi_if.slave  bus
);

    // Elaboration-time parameter sanity
    if (CNT_W < DIV_W) begin : g_bad_cnt_w
        $error("divisor_clk_multi: CNT_W must be >= DIV_W");
    end
    if (N_CH < 1) begin : g_bad_n_ch
        $error("divisor_clk_multi: N_CH must be >= 1");
    end

    logic [CNT_W-1:0] r_cnt      [N_CH];
    logic [DIV_W-1:0] r_div_act  [N_CH];
    logic [DIV_W-1:0] r_div_pend [N_CH];
    logic [N_CH-1:0]  r_mode;
    logic [N_CH-1:0]  r_divclk;
    logic [N_CH-1:0]  r_tick;
    logic [N_CH-1:0]  r_pending;

    logic [CNT_W-1:0] w_cnt      [N_CH];
    logic [DIV_W-1:0] w_div_act  [N_CH];
    logic [DIV_W-1:0] w_div_pend [N_CH];
    logic [N_CH-1:0]  w_mode;
    logic [N_CH-1:0]  w_divclk;
    logic [N_CH-1:0]  w_tick;
    logic [N_CH-1:0]  w_pending;

    logic [DIV_W-1:0] w_div_in   [N_CH];
    logic [DIV_W-1:0] w_div_next [N_CH];
    logic [N_CH-1:0]  w_term;

    // Per-channel divisor slice, terminal compare and next-period divisor
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_div_in[g]   = bus.i_div[g*DIV_W +: DIV_W];
        assign w_term[g]     = (r_cnt[g] == CNT_W'(r_div_act[g]));
        // A same-edge load beats a queued one; otherwise a queued one is applied
        assign w_div_next[g] = bus.i_load[g] ? w_div_in[g]
                             : (r_pending[g] ? r_div_pend[g] : r_div_act[g]);
    end

    // Next-state logic: Sync > En=0 > counting (reset handled in the register)
    always_comb begin
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            w_cnt[ch]      = r_cnt[ch];
            w_div_act[ch]  = r_div_act[ch];
            w_div_pend[ch] = r_div_pend[ch];
            w_mode[ch]     = r_mode[ch];
            w_divclk[ch]   = r_divclk[ch];
            w_tick[ch]     = 1'b0;
            w_pending[ch]  = r_pending[ch];

            if (bus.i_sync || !bus.i_en[ch]) begin
                // Restart: outputs parked low, any divisor change lands now
                w_cnt[ch]     = '0;
                w_divclk[ch]  = 1'b0;
                w_div_act[ch] = w_div_next[ch];
                w_pending[ch] = 1'b0;
                w_mode[ch]    = bus.i_mode[ch];
            end else if (w_term[ch]) begin
                w_cnt[ch]     = '0;
                w_tick[ch]    = 1'b1;
                w_div_act[ch] = w_div_next[ch];
                w_pending[ch] = 1'b0;
                w_mode[ch]    = bus.i_mode[ch];
                if (bus.i_mode[ch]) begin
                    // Leaving toggle while high: close that half-period instead of pulsing
                    w_divclk[ch] = !(!r_mode[ch] && r_divclk[ch]);
                end else begin
                    w_divclk[ch] = !r_divclk[ch];
                end
            end else begin
                w_cnt[ch] = r_cnt[ch] + CNT_W'(1);
                if (r_mode[ch]) begin
                    w_divclk[ch] = 1'b0;
                end
                if (bus.i_load[ch]) begin
                    w_div_pend[ch] = w_div_in[ch];
                    w_pending[ch]  = 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                r_cnt[ch]      <= '0;
                r_div_act[ch]  <= DEF_DIV;
                r_div_pend[ch] <= DEF_DIV;
            end
            r_mode    <= '0;
            r_divclk  <= '0;
            r_tick    <= '0;
            r_pending <= '0;
        end else begin
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                r_cnt[ch]      <= w_cnt[ch];
                r_div_act[ch]  <= w_div_act[ch];
                r_div_pend[ch] <= w_div_pend[ch];
            end
            r_mode    <= w_mode;
            r_divclk  <= w_divclk;
            r_tick    <= w_tick;
            r_pending <= w_pending;
        end
    end

    assign bus.o_divclk  = r_divclk;
    assign bus.o_tick    = r_tick;
    assign bus.o_pending = r_pending;

endmodule
